// File: rtl/counter_ctrl_if.sv
// Command bus from counter_ctrl to the downstream 4-bit up/down counter.
interface counter_ctrl_if #(
  parameter int unsigned WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] d_in;
  logic             up_down;
  logic             enable;
  logic             running;

  // Driven by the control stage
  modport master (
    output load,
    output d_in,
    output up_down,
    output enable,
    output running
  );

  // Consumed by the counter
  modport slave (
    input load,
    input d_in,
    input up_down,
    input enable,
    input running
  );
endinterface

// File: rtl/counter_ctrl.sv
// Button/switch front end for the up/down counter: synchronise, debounce,
// edge-detect, then drive load/enable/direction through a run/stop FSM.
module counter_ctrl #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TICK_DIV        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_run,
  input  logic             btn_dir,
  input  logic             btn_load,
  input  logic [WIDTH-1:0] sw,
  counter_ctrl_if.master   bus
);

  localparam int unsigned NBTN     = 3;
  localparam int unsigned BTN_RUN  = 0;
  localparam int unsigned BTN_DIR  = 1;
  localparam int unsigned BTN_LOAD = 2;
  localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned PS_W     = $clog2(TICK_DIV);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  logic [NBTN-1:0]  w_btn_raw;
  logic [NBTN-1:0]  r_btn_s1;
  logic [NBTN-1:0]  r_btn_s2;
  logic [NBTN-1:0]  r_btn_db;
  logic [NBTN-1:0]  r_btn_db_d;
  logic [DB_W-1:0]  r_db_cnt [NBTN];
  logic [WIDTH-1:0] r_sw_s1;
  logic [WIDTH-1:0] r_sw_s2;
  logic [NBTN-1:0]  w_press;
  logic             w_press_run;
  logic             w_press_dir;
  logic             w_press_load;

  state_t           r_state;
  logic [PS_W-1:0]  r_presc;
  logic             r_load;
  logic [WIDTH-1:0] r_d_in;
  logic             r_up_down;
  logic             r_enable;
  logic             r_running;

  assign w_btn_raw    = {btn_load, btn_dir, btn_run};
  // One-cycle press on the rising edge of each debounced level
  assign w_press      = r_btn_db & ~r_btn_db_d;
  assign w_press_run  = w_press[BTN_RUN];
  assign w_press_dir  = w_press[BTN_DIR];
  assign w_press_load = w_press[BTN_LOAD];

  // Two-flop synchronisers for the buttons and the switch bank
  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
    end else begin
      r_btn_s1 <= w_btn_raw;
      r_btn_s2 <= r_btn_s1;
      r_sw_s1  <= sw;
      r_sw_s2  <= r_sw_s1;
    end
  end

  // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_db   <= '0;
      r_btn_db_d <= '0;
      for (int unsigned i = 0; i < NBTN; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_btn_db_d <= r_btn_db;
      for (int unsigned i = 0; i < NBTN; i++) begin
        if (r_btn_s2[i] == r_btn_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db_cnt[i] <= '0;
          r_btn_db[i] <= r_btn_s2[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Run/stop/load FSM with prescaler and registered counter commands
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_STOP;
      r_presc   <= '0;
      r_load    <= 1'b0;
      r_d_in    <= '0;
      r_up_down <= 1'b1;
      r_enable  <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_load    <= 1'b0;
      r_enable  <= 1'b0;
      r_running <= 1'b0;

      if (w_press_dir) begin
        r_up_down <= ~r_up_down;
      end

      // A load press overrides everything, including a simultaneous run press
      if (w_press_load) begin
        r_state <= ST_LOAD;
        r_load  <= 1'b1;
        r_d_in  <= r_sw_s2;
      end else begin
        case (r_state)
          ST_STOP: begin
            if (w_press_run) begin
              r_state   <= ST_RUN;
              r_presc   <= '0;
              r_running <= 1'b1;
            end
          end
          ST_RUN: begin
            if (w_press_run) begin
              r_state <= ST_STOP;
            end else begin
              r_running <= 1'b1;
              r_enable  <= (r_presc == PS_LAST);
              r_presc   <= (r_presc == PS_LAST) ? '0 : r_presc + PS_W'(1);
            end
          end
          ST_LOAD: begin
            r_state <= ST_STOP;
          end
          default: begin
            r_state <= ST_STOP;
          end
        endcase
      end
    end
  end

  assign bus.load    = r_load;
  assign bus.d_in    = r_d_in;
  assign bus.up_down = r_up_down;
  assign bus.enable  = r_enable;
  assign bus.running = r_running;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: sliding-window debounce/timing model plus directed literal checks.
module tb_counter_ctrl;

  localparam int unsigned W  = 4;
  localparam int unsigned DB = 4;
  localparam int unsigned TD = 8;

  logic         clk;
  logic         rst;
  logic         btn_run;
  logic         btn_dir;
  logic         btn_load;
  logic [W-1:0] sw;

  int n_checks = 0;
  int n_err    = 0;

  counter_ctrl_if #(.WIDTH(W)) bus ();

  counter_ctrl #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(DB),
    .TICK_DIV(TD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_run(btn_run),
    .btn_dir(btn_dir),
    .btn_load(btn_load),
    .sw(sw),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Samples as seen at each clock edge; a level is accepted once the last DB
  // synchronised samples (raw delayed by 2 edges) all disagree with it.
  localparam int M_STOP = 0;
  localparam int M_RUN  = 1;
  localparam int M_LOAD = 2;

  logic [2:0]   hist    [$];
  logic [W-1:0] sw_hist [$];
  logic [2:0]   m_deb;
  logic [2:0]   m_rose;
  int           m_mode;
  int           m_entry;
  int           e_cnt   = 0;
  bit           m_valid = 1'b0;
  logic         m_load, m_enable, m_up, m_running;
  logic [W-1:0] m_din;

  always @(posedge clk) begin : model
    logic [2:0] press;
    bit         all_opp;
    hist.push_back(rst ? 3'b000 : {btn_load, btn_dir, btn_run});
    sw_hist.push_back(rst ? '0 : sw);
    if (rst) begin
      m_deb     = '0;
      m_rose    = '0;
      m_mode    = M_STOP;
      m_entry   = 0;
      m_load    = 1'b0;
      m_enable  = 1'b0;
      m_up      = 1'b1;
      m_running = 1'b0;
      m_din     = '0;
    end else begin
      press    = m_rose;
      m_load   = 1'b0;
      m_enable = 1'b0;
      if (press[1]) m_up = ~m_up;
      if (press[2]) begin
        m_mode = M_LOAD;
        m_load = 1'b1;
        m_din  = (e_cnt >= 2) ? sw_hist[e_cnt-2] : '0;
      end else if (m_mode == M_LOAD) begin
        m_mode = M_STOP;
      end else if (press[0]) begin
        if (m_mode == M_RUN) m_mode = M_STOP;
        else begin
          m_mode  = M_RUN;
          m_entry = e_cnt;
        end
      end else if (m_mode == M_RUN && ((e_cnt - m_entry) % TD) == 0) begin
        m_enable = 1'b1;
      end
      m_running = (m_mode == M_RUN);
      m_rose = '0;
      if (e_cnt >= int'(DB) + 1) begin
        for (int b = 0; b < 3; b++) begin
          all_opp = 1'b1;
          for (int k = e_cnt - int'(DB) - 1; k <= e_cnt - 2; k++) begin
            if (hist[k][b] == m_deb[b]) all_opp = 1'b0;
          end
          if (all_opp) begin
            m_deb[b]  = ~m_deb[b];
            m_rose[b] = m_deb[b];
          end
        end
      end
    end
    e_cnt++;
    m_valid = 1'b1;
  end

  // Every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_load",    8'(bus.load),    8'(m_load));
      chk("m_d_in",    8'(bus.d_in),    8'(m_din));
      chk("m_up_down", 8'(bus.up_down), 8'(m_up));
      chk("m_enable",  8'(bus.enable),  8'(m_enable));
      chk("m_running", 8'(bus.running), 8'(m_running));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_load"},    8'(bus.load),    8'h0);
    chk({tag, "_enable"},  8'(bus.enable),  8'h0);
    chk({tag, "_running"}, 8'(bus.running), 8'h0);
    chk({tag, "_up_down"}, 8'(bus.up_down), 8'h1);
    chk({tag, "_d_in"},    8'(bus.d_in),    8'h0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t, limit 200000", $time);
    $fatal(1);
  end

  initial begin : stim
    rst = 1'b1; btn_run = 1'b0; btn_dir = 1'b0; btn_load = 1'b0; sw = '0;

    // Reset held for 3 edges with buttons toggling
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_reset_vals("rst_hold");
      btn_run = ~btn_run; btn_dir = ~btn_dir; btn_load = ~btn_load; sw = sw + 4'h1;
    end
    rst = 1'b0; btn_run = 1'b0; btn_dir = 1'b0; btn_load = 1'b0; sw = '0;
    step(1);
    chk_reset_vals("rst_release");
    step(10);

    // Run: running at edge 7, enables every 8 cycles, second press stops
    btn_run = 1'b1;
    step(6); chk("run_edge6_running", 8'(bus.running), 8'h0);
    step(1); chk("run_edge7_running", 8'(bus.running), 8'h1);
    btn_run = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 7; i++) begin
        step(1); chk("run_no_enable", 8'(bus.enable), 8'h0);
      end
      step(1); chk("run_enable_tick", 8'(bus.enable), 8'h1);
    end
    btn_run = 1'b1;
    step(6); chk("stop_edge6_running", 8'(bus.running), 8'h1);
    step(1); chk("stop_edge7_running", 8'(bus.running), 8'h0);
    btn_run = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1); chk("stop_enable", 8'(bus.enable), 8'h0);
    end

    // Load while running
    btn_run = 1'b1;
    step(7); chk("load_pre_running", 8'(bus.running), 8'h1);
    btn_run = 1'b0;
    step(2);
    sw = 4'hA; btn_load = 1'b1;
    step(6); chk("load_edge6", 8'(bus.load), 8'h0);
    step(1);
    chk("load_strobe",  8'(bus.load),    8'h1);
    chk("load_d_in",    8'(bus.d_in),    8'hA);
    chk("load_enable",  8'(bus.enable),  8'h0);
    chk("load_running", 8'(bus.running), 8'h0);
    step(1);
    chk("load_after_strobe",  8'(bus.load),    8'h0);
    chk("load_after_running", 8'(bus.running), 8'h0);
    btn_load = 1'b0; sw = 4'h3;
    step(10); chk("load_d_in_held", 8'(bus.d_in), 8'hA);

    // Bounce on btn_dir: glitches of 1, 2, 3 cycles are ignored
    for (int g = 1; g <= 3; g++) begin
      btn_dir = 1'b1;
      step(g);
      btn_dir = 1'b0;
      step(12);
      chk("bounce_up_down", 8'(bus.up_down), 8'h1);
    end
    btn_dir = 1'b1;
    step(7); chk("dir_press1", 8'(bus.up_down), 8'h0);
    step(3); btn_dir = 1'b0;
    step(10);
    btn_dir = 1'b1;
    step(7); chk("dir_press2", 8'(bus.up_down), 8'h1);
    step(3); btn_dir = 1'b0;
    step(10);

    // Simultaneous load and run from STOP: load wins
    sw = 4'h5;
    step(3);
    btn_load = 1'b1; btn_run = 1'b1;
    step(7);
    chk("simul_load",    8'(bus.load),    8'h1);
    chk("simul_d_in",    8'(bus.d_in),    8'h5);
    chk("simul_running", 8'(bus.running), 8'h0);
    step(1);
    chk("simul_after_load",    8'(bus.load),    8'h0);
    chk("simul_after_running", 8'(bus.running), 8'h0);
    step(5); chk("simul_stays_stop", 8'(bus.running), 8'h0);
    btn_load = 1'b0; btn_run = 1'b0;
    step(12);

    // Reset in the middle of a RUN prescaler period, run button held through it
    btn_run = 1'b1;
    step(7); chk("midrst_running", 8'(bus.running), 8'h1);
    step(3);
    rst = 1'b1;
    step(1); chk_reset_vals("midrst");
    step(2);
    rst = 1'b0;
    step(6); chk("midrst_edge6_running", 8'(bus.running), 8'h0);
    step(1); chk("midrst_edge7_running", 8'(bus.running), 8'h1);
    btn_run = 1'b0;
    step(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
- Front-end control stage that sits directly upstream of the 4-bit up/down counter and drives its load, d_in, up_down and enable inputs.
- Converts raw board push-buttons and slide switches into clean single-cycle commands: synchronise, debounce, then edge-detect.
- Runs a run/stop state machine and a prescaler that generates a counting enable at a fixed tick rate.

Parameters:
- WIDTH, 4: width of sw and d_in; matches the counter width.
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised cycles required before a button level is accepted; minimum 2. Board builds override with a larger value.
- TICK_DIV, 8: clock cycles per enable pulse while running; minimum 2.

Ports:
- clk  input  1  system clock; the only clock in the block.
- rst  input  1  reset; synchronous, active-high.
- btn_run  input  1  raw asynchronous button; a press toggles run/stop.
- btn_dir  input  1  raw asynchronous button; a press toggles count direction.
- btn_load  input  1  raw asynchronous button; a press loads the sw value.
- sw  input  WIDTH  raw asynchronous switches; load value.
- load  output  1  one-cycle load strobe to the counter.
- d_in  output  WIDTH  load data to the counter; registered.
- up_down  output  1  direction to the counter; 1 = up, 0 = down.
- enable  output  1  one-cycle count strobe to the counter.
- running  output  1  high while the FSM is in RUN.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. All state is sampled on posedge clk.
- Reset values: load=0, d_in=0, up_down=1, enable=0, running=0, FSM=STOP, prescaler=0. Synchronisers, debounce counters and debounced levels are all 0.
- Reset mid-operation: state is cleared on the first clk edge with rst=1. No strobe is issued while rst=1.
- Input conditioning:
  - Each button and sw uses a 2-flop synchroniser.
  - Each button has a debounce counter. It counts while the synchronised level differs from the debounced level and clears to 0 when they match.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level takes the synchronised value.
  - A press pulse is the one-cycle rising edge of the debounced level. Releases generate nothing.
  - Any pulse shorter than DEBOUNCE_CYCLES synchronised cycles is ignored.
  - A button held through reset release produces exactly one press after debounce.
- Latency: a raw button rise that is held produces its registered output effect at edge DEBOUNCE_CYCLES+3 after the first edge that samples it high. With defaults that is edge 7. The latency is fixed and identical for all three buttons.
- FSM states: STOP, RUN, LOAD.
  - STOP --run press--> RUN. Prescaler clears to 0 on entry.
  - RUN --run press--> STOP.
  - Any state --load press--> LOAD. d_in captures synchronised sw in the same edge.
  - LOAD --> STOP unconditionally after 1 cycle. The counter is always stopped after a load.
  - Simultaneous load and run press: load wins and the run press is discarded.
- Load strobe: load=1 exactly for the single cycle in LOAD. d_in holds its captured value until the next load.
- Enable generation:
  - The prescaler counts 0..TICK_DIV-1 only in RUN and wraps to 0.
  - enable=1 for one cycle when prescaler==TICK_DIV-1 in RUN, so the first enable falls TICK_DIV cycles after entering RUN.
  - enable=0 in STOP and LOAD.
  - load and enable are never high in the same cycle.
  - Stopping freezes nothing; re-entering RUN restarts the prescaler from 0.
- Direction: up_down toggles on each dir press in any state. The new value is visible in the same cycle as the FSM effect of any simultaneous press. A dir press coinciding with an enable takes effect from the next enable onward.
- running: a registered decode of state==RUN.

Test Plan (DEBOUNCE_CYCLES=4, TICK_DIV=8):
- Reset: assert rst for 3 cycles with buttons toggling. Required: load=0, enable=0, running=0, up_down=1 and d_in=0 throughout, and 1 cycle after rst falls.
- Run: hold btn_run high. Required: running=1 at edge 7, first enable 8 cycles later, then enable every 8th cycle. A second press sets running=0 and enable stays 0.
- Load: sw=4'hA, press btn_load while RUN. Required: a single load=1 cycle with d_in=4'hA, enable=0 in that cycle, then running=0. Changing sw to 4'h3 afterwards leaves d_in=4'hA.
- Bounce: apply btn_dir glitches of 1, 2 and 3 cycles. Required: up_down stays 1. A clean 10-cycle press sets up_down=0, and a second press restores 1.
- Simultaneous: btn_load and btn_run rise together from STOP with sw=4'h5. Required: one load with d_in=4'h5, then STOP and running=0.
- Mid-op reset: assert rst 3 cycles into a RUN prescaler period. Required: enable=0 the next cycle and all outputs at reset values. A btn_run held through reset gives running=1 at edge 7 after release.
